// File: rtl/program_word_encoder.sv
// Re-encodes decoded instruction tuples into 16-bit ARMAria words and streams
// them into instruction memory through a stage register and a 2-entry FIFO.
module program_word_encoder #(
    parameter int unsigned                ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS  = ADDRESS_WIDTH'(2048)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [6:0]               i_id,
    input  logic [3:0]               i_reg_d,
    input  logic [3:0]               i_reg_a,
    input  logic [3:0]               i_reg_b,
    input  logic [11:0]              i_offset,
    input  logic [4:0]               i_branch_condition,
    output logic                     o_mem_write,
    input  logic                     i_mem_ready,
    output logic [ADDRESS_WIDTH-1:0] o_mem_address,
    output logic [15:0]              o_mem_data,
    output logic                     o_illegal,
    output logic [15:0]              o_word_count,
    output logic [7:0]               o_error_count
);

    logic [2:0]  w_d, w_a, w_b;
    logic [7:0]  w_off;
    logic [3:0]  w_cond;
    logic [6:0]  w_m4, w_m12, w_m27, w_m30, w_m34, w_m40, w_m48, w_m59, w_m63, w_m69;
    logic [3:0]  w_op48;
    logic [15:0] w_enc;
    logic        w_legal;

    // High Reg/Offset/cond bits are dropped here, never flagged.
    assign w_d    = i_reg_d[2:0];
    assign w_a    = i_reg_a[2:0];
    assign w_b    = i_reg_b[2:0];
    assign w_off  = i_offset[7:0];
    assign w_cond = i_branch_condition[3:0];

    assign w_m4   = i_id - 7'd4;
    assign w_m12  = i_id - 7'd12;
    assign w_m27  = i_id - 7'd27;
    assign w_m30  = i_id - 7'd30;
    assign w_m34  = i_id - 7'd34;
    assign w_m40  = i_id - 7'd40;
    assign w_m48  = i_id - 7'd48;
    assign w_m59  = i_id - 7'd59;
    assign w_m63  = i_id - 7'd63;
    assign w_m69  = i_id - 7'd69;
    assign w_op48 = 4'd6 + {2'b00, w_m48[2:1]};

    always_comb begin
        w_enc   = 16'h0000;
        w_legal = 1'b1;
        if (i_id == 7'd1 || i_id == 7'd2)
            w_enc = {4'b0000, i_id == 7'd2, w_off[4:0], w_a, w_d};
        else if (i_id == 7'd3)
            w_enc = {4'b0001, 1'b0, w_off[4:0], w_a, w_d};
        else if (i_id >= 7'd4 && i_id <= 7'd7)
            w_enc = {4'b0001, 1'b1, w_m4[1:0], (i_id <= 7'd5) ? w_b : w_off[2:0], w_a, w_d};
        else if (i_id >= 7'd8 && i_id <= 7'd11)
            w_enc = {(i_id <= 7'd9) ? 4'd2 : 4'd3, i_id[0], w_d, w_off};
        else if (i_id >= 7'd12 && i_id <= 7'd27)
            w_enc = {4'b0100, 1'b0, 1'b0, w_m12[3:2], w_m12[1:0], w_b, w_d};
        else if (i_id >= 7'd28 && i_id <= 7'd30)
            w_enc = {4'b0100, 4'd4, w_m27[1:0], w_b, w_d};
        else if (i_id >= 7'd31 && i_id <= 7'd33)
            w_enc = {4'b0100, 4'd5, w_m30[1:0], w_b, w_d};
        else if (i_id >= 7'd34 && i_id <= 7'd37)
            w_enc = {4'b0100, 4'd6, w_m34[1:0], w_b, w_d};
        else if (i_id == 7'd38 || i_id == 7'd77) begin
            // Condition 4'hF is reserved for ID 77; ID 38 may not produce it.
            w_enc   = {4'b0100, 4'b0111, (i_id == 7'd77) ? 4'hF : w_cond, 1'b0, w_b};
            w_legal = (i_id == 7'd77) || (w_cond != 4'hF);
        end
        else if (i_id == 7'd39)
            w_enc = {4'b0100, 1'b1, w_d, w_off};
        else if (i_id >= 7'd40 && i_id <= 7'd47)
            w_enc = {4'b0101, w_m40[2:0], w_b, w_a, w_d};
        else if (i_id >= 7'd48 && i_id <= 7'd53)
            w_enc = {w_op48, w_m48[0], w_off[4:0], w_a, w_d};
        else if (i_id >= 7'd54 && i_id <= 7'd57)
            w_enc = {(i_id <= 7'd55) ? 4'd9 : 4'd10, i_id[0], w_d, w_off};
        else if (i_id == 7'd58 || i_id == 7'd76)
            w_enc = {4'b1011, 4'b0000, 1'b0, i_id == 7'd76, 3'b000, w_d};
        else if (i_id >= 7'd59 && i_id <= 7'd62)
            w_enc = {4'b1011, 4'b0010, w_m59[1:0], w_b, w_d};
        else if (i_id >= 7'd63 && i_id <= 7'd66)
            w_enc = {4'b1011, 4'b1010, w_m63[1:0], w_b, w_d};
        else if (i_id == 7'd67)
            w_enc = {4'b1011, 4'b0100, 5'b00000, w_d};
        else if (i_id == 7'd68)
            w_enc = {4'b1011, 4'b1101, 5'b00000, w_d};
        else if (i_id >= 7'd69 && i_id <= 7'd71)
            w_enc = {4'b1011, 4'b1110, w_m69[1:0], 3'b000, (i_id == 7'd70) ? 3'b000 : w_d};
        else if (i_id == 7'd72)
            w_enc = 16'hC000;
        else if (i_id == 7'd73)
            w_enc = {4'b1101, w_cond, w_off};
        else if (i_id == 7'd74)
            w_enc = 16'hE000;
        else if (i_id == 7'd75)
            w_enc = 16'hE800;
        else if (i_id == 7'd100)
            w_enc = 16'hFFFF;
        else
            w_legal = 1'b0;
    end

    logic                     r_s_valid, r_s_legal;
    logic [15:0]              r_s_word;
    logic [15:0]              r_fifo [2];
    logic                     r_rd_ptr, r_wr_ptr;
    logic [1:0]               r_count;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [15:0]              r_word_count;
    logic [7:0]               r_error_count;

    logic w_accept, w_pop, w_push, w_s_free;

    assign o_in_ready  = ({1'b0, r_s_valid} + r_count) <= 2'd1;
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_mem_write = (r_count != 2'd0);
    assign w_pop       = o_mem_write && i_mem_ready;
    // A full FIFO can still take S when its head leaves in the same cycle.
    assign w_push      = r_s_valid && r_s_legal && ((r_count != 2'd2) || w_pop);
    assign w_s_free    = !r_s_valid || !r_s_legal || w_push;

    assign o_mem_data    = o_mem_write ? r_fifo[r_rd_ptr] : 16'h0000;
    assign o_illegal     = r_s_valid && !r_s_legal;
    assign o_mem_address = r_address;
    assign o_word_count  = r_word_count;
    assign o_error_count = r_error_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s_valid     <= 1'b0;
            r_s_legal     <= 1'b0;
            r_s_word      <= 16'h0000;
            r_fifo[0]     <= 16'h0000;
            r_fifo[1]     <= 16'h0000;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_address     <= BASE_ADDRESS;
            r_word_count  <= 16'h0000;
            r_error_count <= 8'h00;
        end else begin
            if (w_accept) begin
                r_s_valid <= 1'b1;
                r_s_legal <= w_legal;
                r_s_word  <= w_enc;
            end else if (w_s_free) begin
                r_s_valid <= 1'b0;
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_s_word;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (o_illegal && r_error_count != 8'hFF)
                r_error_count <= r_error_count + 8'd1;
            if (i_start) begin
                r_address    <= BASE_ADDRESS;
                r_word_count <= 16'h0000;
            end else if (w_pop) begin
                r_address    <= r_address + 1'b1;
                r_word_count <= r_word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_program_word_encoder.sv
// Directed bench: expected words/addresses are queued as tuples are driven and
// compared whenever the encoder hands a word to memory.
module tb_program_word_encoder;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [6:0]  i_id = '0;
    logic [3:0]  i_reg_d = '0, i_reg_a = '0, i_reg_b = '0;
    logic [11:0] i_offset = '0;
    logic [4:0]  i_branch_condition = '0;
    logic        o_mem_write;
    logic        i_mem_ready = 1'b1;
    logic [15:0] o_mem_address, o_mem_data, o_word_count;
    logic        o_illegal;
    logic [7:0]  o_error_count;

    logic        w_mem_write, w_illegal, w_in_ready;
    logic [15:0] w_mem_address, w_mem_data, w_word_count;
    logic [7:0]  w_error_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t        sb[$];
    logic [15:0] exp_addr = 16'd2048;

    always #5 i_clock = ~i_clock;

    program_word_encoder #(.ADDRESS_WIDTH(16), .BASE_ADDRESS(16'd2048)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_id(i_id), .i_reg_d(i_reg_d), .i_reg_a(i_reg_a), .i_reg_b(i_reg_b),
        .i_offset(i_offset), .i_branch_condition(i_branch_condition),
        .o_mem_write(o_mem_write), .i_mem_ready(i_mem_ready),
        .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
        .o_illegal(o_illegal), .o_word_count(o_word_count), .o_error_count(o_error_count)
    );

    // Second instance based at the top of the address space to see the wrap.
    program_word_encoder #(.ADDRESS_WIDTH(16), .BASE_ADDRESS(16'hFFFF)) u_wrap (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
        .i_in_valid(i_in_valid), .o_in_ready(w_in_ready),
        .i_id(i_id), .i_reg_d(i_reg_d), .i_reg_a(i_reg_a), .i_reg_b(i_reg_b),
        .i_offset(i_offset), .i_branch_condition(i_branch_condition),
        .o_mem_write(w_mem_write), .i_mem_ready(i_mem_ready),
        .o_mem_address(w_mem_address), .o_mem_data(w_mem_data),
        .o_illegal(w_illegal), .o_word_count(w_word_count), .o_error_count(w_error_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge i_clock) begin
        if (!i_reset && o_mem_write && i_mem_ready) begin
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("mem_address", o_mem_address, e.addr);
                check("mem_data", o_mem_data, e.data);
            end
        end
    end

    task automatic push_exp(input logic [15:0] data);
        sb.push_back('{addr: exp_addr, data: data});
        exp_addr = exp_addr + 16'd1;
    endtask

    task automatic set_fields(input logic [6:0] id, input logic [3:0] d, input logic [3:0] a,
                              input logic [3:0] b, input logic [11:0] off, input logic [4:0] cond);
        i_id = id; i_reg_d = d; i_reg_a = a; i_reg_b = b;
        i_offset = off; i_branch_condition = cond;
    endtask

    // Holds the offered tuple until it is taken; returns 1 ns after that edge.
    task automatic wait_accept();
        int t = 0;
        i_in_valid = 1'b1;
        while (!o_in_ready && t < 200) begin
            @(posedge i_clock); #1;
            t++;
        end
        check("accept_timeout", t < 200, 1);
        @(posedge i_clock); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic send(input logic [6:0] id, input logic [3:0] d, input logic [3:0] a,
                        input logic [3:0] b, input logic [11:0] off, input logic [4:0] cond);
        set_fields(id, d, a, b, off, cond);
        wait_accept();
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge i_clock);
            t++;
        end
        check("drain", sb.size(), 0);
        @(posedge i_clock); #1;
    endtask

    task automatic check_reset_state();
        check("rst_in_ready", o_in_ready, 1);
        check("rst_mem_write", o_mem_write, 0);
        check("rst_mem_data", o_mem_data, 16'h0000);
        check("rst_illegal", o_illegal, 0);
        check("rst_mem_address", o_mem_address, 16'd2048);
        check("rst_word_count", o_word_count, 0);
        check("rst_error_count", o_error_count, 0);
    endtask

    typedef struct {
        logic [6:0]  id;
        logic [3:0]  d, a, b;
        logic [11:0] off;
        logic [4:0]  cond;
        logic        legal;
        logic [15:0] word;
    } vec_t;

    vec_t vecs[16] = '{
        '{7'd5,   4'd7, 4'd2, 4'd6, 12'h000, 5'h00, 1'b1, 16'h1B97},
        '{7'd20,  4'd4, 4'd0, 4'd3, 12'h000, 5'h00, 1'b1, 16'h421C},
        '{7'd35,  4'd2, 4'd0, 4'd1, 12'h000, 5'h00, 1'b1, 16'h464A},
        '{7'd43,  4'd1, 4'd8, 4'd7, 12'h000, 5'h00, 1'b1, 16'h57C1},
        '{7'd51,  4'd2, 4'd1, 4'd0, 12'h01F, 5'h00, 1'b1, 16'h7FCA},
        '{7'd57,  4'd3, 4'd0, 4'd0, 12'h0A5, 5'h00, 1'b1, 16'hABA5},
        '{7'd64,  4'd5, 4'd0, 4'd2, 12'h000, 5'h00, 1'b1, 16'hBA55},
        '{7'd70,  4'd7, 4'd0, 4'd0, 12'h000, 5'h00, 1'b1, 16'hBE40},
        '{7'd9,   4'd6, 4'd0, 4'd0, 12'hF3C, 5'h00, 1'b1, 16'h2E3C},
        '{7'd38,  4'd0, 4'd0, 4'd2, 12'h000, 5'h13, 1'b1, 16'h4732},
        '{7'd3,   4'd5, 4'd4, 4'd0, 12'h01A, 5'h00, 1'b1, 16'h16A5},
        '{7'd67,  4'd3, 4'd0, 4'd0, 12'h000, 5'h00, 1'b1, 16'hB403},
        '{7'd75,  4'd0, 4'd0, 4'd0, 12'h000, 5'h00, 1'b1, 16'hE800},
        '{7'd0,   4'd1, 4'd1, 4'd1, 12'h001, 5'h00, 1'b0, 16'h0000},
        '{7'd78,  4'd1, 4'd1, 4'd1, 12'h001, 5'h00, 1'b0, 16'h0000},
        '{7'd101, 4'd1, 4'd1, 4'd1, 12'h001, 5'h00, 1'b0, 16'h0000}
    };

    initial begin
        logic [15:0] wc_before;

        repeat (3) @(posedge i_clock);
        #1 i_reset = 1'b0;
        @(negedge i_clock);
        check_reset_state();

        // Single word: 2-cycle latency to mem_write
        @(posedge i_clock); #1;
        push_exp(16'h0959);
        send(7'd2, 4'd1, 4'd3, 4'd0, 12'd5, 5'd0);
        @(negedge i_clock);
        check("lat_stage_no_write", o_mem_write, 0);
        check("lat_no_illegal", o_illegal, 0);
        @(negedge i_clock);
        check("lat_write", o_mem_write, 1);
        @(posedge i_clock); #1;
        check("addr_after_one", o_mem_address, 16'd2049);
        check("wc_after_one", o_word_count, 1);
        check("wrap_addr", w_mem_address, 16'h0000);

        // start, then three-word sequence
        i_start = 1'b1;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        exp_addr = 16'd2048;
        check("start_addr", o_mem_address, 16'd2048);
        check("start_wc", o_word_count, 0);
        push_exp(16'hD010);
        push_exp(16'h4A44);
        push_exp(16'hFFFF);
        send(7'd73, 4'd0, 4'd0, 4'd0, 12'h010, 5'd0);
        send(7'd39, 4'd2, 4'd0, 4'd0, 12'h044, 5'd0);
        send(7'd100, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0);
        drain();
        check("seq_wc", o_word_count, 3);
        check("seq_addr", o_mem_address, 16'd2051);

        // ID 77 forces cond F: {0100,0111,1111,0,101}; ID 38 with cond F rejected
        push_exp(16'h47F5);
        send(7'd77, 4'd0, 4'd0, 4'd5, 12'h000, 5'd0);
        send(7'd38, 4'd0, 4'd0, 4'd5, 12'h000, 5'h0F);
        @(negedge i_clock);
        check("illegal_pulse", o_illegal, 1);
        @(negedge i_clock);
        check("illegal_one_cycle", o_illegal, 0);
        check("err_one", o_error_count, 1);
        drain();
        check("illegal_no_write_addr", o_mem_address, 16'd2052);

        // Encoding table, incl. truncated high bits and illegal IDs
        foreach (vecs[i]) begin
            if (vecs[i].legal) push_exp(vecs[i].word);
            send(vecs[i].id, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].off, vecs[i].cond);
        end
        drain();
        check("err_after_table", o_error_count, 4);

        // Backpressure: third tuple stalls until memory frees up
        wc_before = o_word_count;
        i_mem_ready = 1'b0;
        push_exp(16'hE000);
        push_exp(16'hFFFF);
        push_exp(16'hD27E);
        send(7'd74, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0);
        send(7'd100, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0);
        set_fields(7'd73, 4'd0, 4'd0, 4'd0, 12'h07E, 5'd2);
        i_in_valid = 1'b1;
        repeat (4) @(posedge i_clock);
        #1;
        check("bp_not_ready", o_in_ready, 0);
        check("bp_write_held", o_mem_write, 1);
        check("bp_wc_frozen", o_word_count, wc_before);
        i_mem_ready = 1'b1;
        wait_accept();
        drain();

        // start in the same cycle as a write handshake
        push_exp(16'hC000);
        send(7'd72, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0);
        @(posedge i_clock); #1;
        check("sw_write_pending", o_mem_write, 1);
        i_start = 1'b1;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        exp_addr = 16'd2048;
        check("sw_addr", o_mem_address, 16'd2048);
        check("sw_wc", o_word_count, 0);
        push_exp(16'h00CA);
        send(7'd1, 4'd2, 4'd1, 4'd0, 12'h003, 5'd0);
        drain();
        check("sw_next_addr", o_mem_address, 16'd2049);

        // error_count saturation
        for (int n = 0; n < 300; n++)
            send(7'd0, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0);
        @(negedge i_clock);
        @(negedge i_clock);
        check("err_saturate", o_error_count, 8'd255);

        // Reset with words still buffered
        i_mem_ready = 1'b0;
        send(7'd100, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0);
        send(7'd74, 4'd0, 4'd0, 4'd0, 12'h000, 5'd0);
        @(posedge i_clock); #1;
        check("pre_reset_buffered", o_mem_write, 1);
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        @(negedge i_clock);
        check_reset_state();
        i_mem_ready = 1'b1;
        repeat (4) @(negedge i_clock);
        check("post_reset_no_write", o_mem_write, 0);
        check("sb_empty_end", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
